// File: rtl/add_arbiter.sv
// Round-robin scheduler sharing one 32-bit adder between NREQ requesters.
// A single-entry result register carries sum, carry and owner ID behind a valid/ready handshake.
module add_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [32*NREQ-1:0] req_a,
   input  logic [32*NREQ-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_sum,
   output logic               rsp_carry,
   output logic [IDW-1:0]     rsp_id,
   output logic [15:0]        op_count
);
   localparam int IW = IDW + 1;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} res_state_t;

   res_state_t      state_r;
   logic [IDW-1:0]  ptr_r;
   logic [31:0]     sum_r;
   logic            carry_r;
   logic [IDW-1:0]  id_r;
   logic [15:0]     count_r;

   logic            found_s;
   logic [IDW-1:0]  win_s;
   logic [IW-1:0]   cand_s;
   logic [IW-1:0]   idx_s;
   logic            can_accept_s;
   logic            xfer_s;
   logic [IDW-1:0]  nxt_ptr_s;
   logic [31:0]     a_sel_s;
   logic [31:0]     b_sel_s;
   logic [32:0]     add_s;

   // The shared adder: unsigned 32-bit add with no carry-in, bit 32 is the carry-out.
   function automatic logic [32:0] add32(input logic [31:0] a, input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Round-robin search starting at ptr_r; the index is reduced mod NREQ so it never leaves range.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      cand_s  = '0;
      idx_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = {1'b0, ptr_r} + IW'(k);
         idx_s  = (cand_s >= IW'(NREQ)) ? (cand_s - IW'(NREQ)) : cand_s;
         if (!found_s && req_valid[idx_s[IDW-1:0]]) begin
            found_s = 1'b1;
            win_s   = idx_s[IDW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign can_accept_s = (state_r == EMPTY) || rsp_ready;
   assign xfer_s       = found_s && can_accept_s;
   assign nxt_ptr_s    = (win_s == IDW'(NREQ - 1)) ? '0 : (win_s + IDW'(1));
   assign a_sel_s      = req_a[{win_s, 5'b00000} +: 32];
   assign b_sel_s      = req_b[{win_s, 5'b00000} +: 32];
   assign add_s        = add32(a_sel_s, b_sel_s);

   // Grant is one-hot on the winner and forced low while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && xfer_s) begin
         req_ready[win_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Result register, round-robin pointer and accept counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= EMPTY;
         ptr_r   <= '0;
         sum_r   <= 32'h0000_0000;
         carry_r <= 1'b0;
         id_r    <= '0;
         count_r <= 16'h0000;
      end else if (xfer_s) begin
         state_r <= FULL;
         ptr_r   <= nxt_ptr_s;
         sum_r   <= add_s[31:0];
         carry_r <= add_s[32];
         id_r    <= win_s;
         count_r <= count_r + 16'd1;
      end else if ((state_r == FULL) && rsp_ready) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_r;
      end
   end

   assign rsp_valid = (state_r == FULL);
   assign rsp_sum   = sum_r;
   assign rsp_carry = carry_r;
   assign rsp_id    = id_r;
   assign op_count  = count_r;

endmodule
